// File: rtl/cmp_arb_pkg.sv
// Shared types for the comparator arbiter: FSM
// state encoding, default sizes, result flag bundle.
package cmp_arb_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int W_DEF     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RSP  = 2'd2
  } state_t;

  typedef struct packed {
    logic equal;
    logic lesser;
    logic greater;
  } flags_t;

endpackage

// File: rtl/comparator_arbiter_if.sv
// Request/operand/response bundle of the arbiter.
// master: requesters + consumer; slave: arbiter.
interface comparator_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 4
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] a_bus;
  logic [N_REQ*W-1:0] b_bus;
  logic [N_REQ-1:0]   gnt;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic               rsp_equal;
  logic               rsp_lesser;
  logic               rsp_greater;
  logic               rsp_ready;
  logic               busy;

  modport master (
    output req, a_bus, b_bus, rsp_ready,
    input  gnt, rsp_valid, rsp_id,
    input  rsp_equal, rsp_lesser, rsp_greater,
    input  busy
  );

  modport slave (
    input  req, a_bus, b_bus, rsp_ready,
    output gnt, rsp_valid, rsp_id,
    output rsp_equal, rsp_lesser, rsp_greater,
    output busy
  );

endinterface

// File: rtl/cmp_core.sv
// Combinational unsigned W-bit compare.
// a, b in; one-hot equal/lesser/greater flags out.
module cmp_core
  import cmp_arb_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output flags_t       flags
);

  assign flags.equal   = (a == b);
  assign flags.lesser  = (a < b);
  assign flags.greater = (a > b);

endmodule

// File: rtl/comparator_arbiter.sv
// Round-robin arbiter sharing one comparator.
// Ports: clk, rst (sync, high), bus (slave).
module comparator_arbiter
  import cmp_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF
) (
  input logic clk,
  input logic rst,
  comparator_arbiter_if.slave bus
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             rv_q, rv_d;
  logic             busy_q, busy_d;
  flags_t           flags_q, flags_d;
  flags_t           core_flags;

  logic             win_found;
  logic [IDW-1:0]   win_id;
  logic [W-1:0]     a_sel;
  logic [W-1:0]     b_sel;

  cmp_core #(.W(W)) u_core (
    .a     (a_q),
    .b     (b_q),
    .flags (core_flags)
  );

  // Scan from ptr upward, wrapping; first set
  // request wins.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr_q) + i) % N_REQ;
      if (!win_found && bus.req[idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (k == int'(win_id)) begin
        a_sel = bus.a_bus[k*W +: W];
        b_sel = bus.b_bus[k*W +: W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    gnt_d   = '0;
    rv_d    = rv_q;
    busy_d  = busy_q;
    flags_d = flags_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = CMP;
          id_d    = win_id;
          a_d     = a_sel;
          b_d     = b_sel;
          gnt_d   = N_REQ'(1) << win_id;
          busy_d  = 1'b1;
        end
      end
      CMP: begin
        state_d = RSP;
        flags_d = core_flags;
        rv_d    = 1'b1;
      end
      RSP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
          rv_d    = 1'b0;
          flags_d = '0;
          busy_d  = 1'b0;
          ptr_d   = (id_q == IDW'(N_REQ - 1))
                    ? '0 : id_q + IDW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        rv_d    = 1'b0;
        flags_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      gnt_q   <= '0;
      rv_q    <= 1'b0;
      busy_q  <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gnt_q   <= gnt_d;
      rv_q    <= rv_d;
      busy_q  <= busy_d;
      flags_q <= flags_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.rsp_valid   = rv_q;
  assign bus.rsp_id      = id_q;
  assign bus.rsp_equal   = flags_q.equal;
  assign bus.rsp_lesser  = flags_q.lesser;
  assign bus.rsp_greater = flags_q.greater;
  assign bus.busy        = busy_q;

endmodule
